fp_decompression: RTL and testbench

- Sequential inverse of the linear-to-float compression block: expands an 8-bit float (1 sign, 3-bit exponent, 4-bit significand) back to a 12-bit two's-complement linear sample.
- Sits on the receive side of the compressed-sample path and rebuilds the linear value from the compressed triple.
- Expansion is iterative: one left shift per clock, controlled by a small FSM, with valid/ready handshakes on both sides.
- Reconstruction rule: D = (-1)^sign * (sig << exp).

---
 rtl/fp_decompression.sv | 82 ++++++++
 tb/tb_fp_decompression.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_decompression.sv
// Iterative float-to-linear expander: rebuilds D = (-1)^sign * (sig << exp)
// one left shift per clock, with valid/ready handshakes on both sides.
module fp_decompression #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign,
    input  logic [EXP_W-1:0] exp_in,
    input  logic [SIG_W-1:0] sig_in,
    output logic [OUT_W-1:0] D,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [OUT_W-2:0]   r_mag;
    logic [EXP_W-1:0]   r_count;
    logic               r_sign;
    logic [OUT_W-1:0]   r_d;
    logic               r_out_valid;
    logic [OUT_W-1:0]   w_mag_ext;

    assign w_mag_ext = {1'b0, r_mag};
    assign in_ready  = (r_state == S_IDLE);
    assign D         = r_d;
    assign out_valid = r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mag       <= '0;
            r_count     <= '0;
            r_sign      <= 1'b0;
            r_d         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mag   <= {{(OUT_W-1-SIG_W){1'b0}}, sig_in};
                        r_count <= exp_in;
                        r_sign  <= sign;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_count != '0) begin
                        r_mag   <= r_mag << 1;
                        r_count <= r_count - EXP_W'(1);
                    end else begin
                        // Negating a zero magnitude yields zero, so -0 maps to 0.
                        r_d         <= r_sign ? (OUT_W'(0) - w_mag_ext) : w_mag_ext;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_decompression.sv
// Self-checking bench for fp_decompression: directed scenarios plus randomized
// conversions compared against an arithmetic reference model.
module tb_fp_decompression;

    logic        clk;
    logic        clk_run;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [2:0]  exp_in;
    logic [3:0]  sig_in;
    logic [11:0] D;
    logic        out_valid;
    logic        out_ready;

    int n_pass;
    int n_total;

    fp_decompression #(.EXP_W(3), .SIG_W(4), .OUT_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .exp_in    (exp_in),
        .sig_in    (sig_in),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk     = 1'b0;
        clk_run = 1'b0;
    end
    always #5 if (clk_run) clk = ~clk;

    function automatic logic [11:0] model(input logic s, input int e, input int g);
        int v;
        v = g * (1 << e);
        if (s) v = -v;
        return 12'(v);
    endfunction

    task automatic accept(input logic s, input logic [2:0] e, input logic [3:0] g);
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
        else n_pass++;
        in_valid = 1'b1;
        sign     = s;
        exp_in   = e;
        sig_in   = g;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sign     = 1'($urandom);
        exp_in   = 3'($urandom);
        sig_in   = 4'($urandom);
    endtask

    task automatic wait_result(input int lat, input logic [11:0] want, input string name);
        int cyc;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid === 1'b1) break;
            n_total++;
            if (in_ready !== 1'b0) $display("FAIL %s_busy: in_ready=%b want 0 cyc=%0d", name, in_ready, cyc);
            else n_pass++;
        end
        n_total++;
        if (cyc !== lat || out_valid !== 1'b1)
            $display("FAIL %s_latency: got %0d cycles valid=%b want %0d", name, cyc, out_valid, lat);
        else n_pass++;
        n_total++;
        if (D !== want) $display("FAIL %s_data: D=%h want %h", name, D, want);
        else n_pass++;
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sign      = 1'b0;
        exp_in    = '0;
        sig_in    = '0;
        out_ready = 1'b0;
        #20;
        n_total++;
        if (D !== 12'h000 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_state: D=%h out_valid=%b in_ready=%b want 000/0/1", D, out_valid, in_ready);
        else n_pass++;
        rst_n   = 1'b1;
        clk_run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL reset_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
            else n_pass++;
        end
    endtask

    task automatic test_directed;
        out_ready = 1'b1;
        accept(1'b0, 3'd7, 4'd15);
        wait_result(8, 12'h780, "sat_pos");
        release_out("sat_pos");
        accept(1'b1, 3'd3, 4'd9);
        wait_result(4, 12'hFB8, "neg_mid");
        release_out("neg_mid");
        accept(1'b1, 3'd0, 4'd0);
        wait_result(1, 12'h000, "neg_zero");
        release_out("neg_zero");
        accept(1'b0, 3'd0, 4'd5);
        wait_result(1, 12'h005, "min_lat");
        release_out("min_lat");
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        accept(1'b0, 3'd2, 4'd12);
        wait_result(3, 12'h030, "bp");
        in_valid = 1'b1;
        sign     = 1'b1;
        exp_in   = 3'd1;
        sig_in   = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (out_valid !== 1'b1 || D !== 12'h030 || in_ready !== 1'b0)
                $display("FAIL bp_hold: out_valid=%b D=%h in_ready=%b want 1/030/0", out_valid, D, in_ready);
            else n_pass++;
        end
        release_out("bp");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_next_accept: in_ready=%b want 0", in_ready);
        else n_pass++;
        wait_result(2, model(1'b1, 1, 3), "bp_next");
        release_out("bp_next");
    endtask

    task automatic test_abort;
        out_ready = 1'b1;
        accept(1'b0, 3'd7, 4'd15);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || D !== 12'h000 || in_ready !== 1'b1)
            $display("FAIL abort_clear: out_valid=%b D=%h in_ready=%b want 0/000/1", out_valid, D, in_ready);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL abort_no_valid: out_valid=%b want 0 cyc=%0d", out_valid, i);
            else n_pass++;
        end
        accept(1'b0, 3'd1, 4'd8);
        wait_result(2, 12'h010, "post_abort");
        release_out("post_abort");
    endtask

    task automatic test_random;
        logic       s;
        logic [2:0] e;
        logic [3:0] g;
        int         stall;
        for (int k = 0; k < 40; k++) begin
            s     = 1'($urandom);
            e     = 3'($urandom);
            g     = 4'($urandom);
            stall = int'($urandom_range(0, 3));
            out_ready = (stall == 0);
            accept(s, e, g);
            wait_result(int'(e) + 1, model(s, int'(e), int'(g)), "rand");
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                #1;
                n_total++;
                if (out_valid !== 1'b1 || D !== model(s, int'(e), int'(g)))
                    $display("FAIL rand_hold: out_valid=%b D=%h want 1/%h", out_valid, D, model(s, int'(e), int'(g)));
                else n_pass++;
            end
            release_out("rand");
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset;
        test_directed;
        test_backpressure;
        test_abort;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
